// File: rtl/md_sequencer_pkg.sv
// Shared constants for the mul/div sequencer and the opcode control decoder.
package md_sequencer_pkg;

    localparam logic [4:0] OPC_RTYPE   = 5'b00000;
    localparam logic [4:0] ALU_MUL     = 5'b00110;
    localparam logic [4:0] ALU_DIV     = 5'b00111;
    localparam logic [4:0] REG_RSTATUS = 5'd30;

    localparam int STATUS_MUL_CODE = 4;
    localparam int STATUS_DIV_CODE = 5;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_WB   = 2'd2
    } md_state_e;

    // True when the instruction is an R-type op with the given ALU op field.
    function automatic logic is_rtype_alu(input logic [4:0] opcode,
                                          input logic [4:0] alu_op,
                                          input logic [4:0] want);
        return (opcode == OPC_RTYPE) && (alu_op == want);
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating up-counter that bounds how long the sequencer waits on multdiv.
module md_timeout_counter #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count busy cycles; hold at all-ones rather than wrapping.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != {CW{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/md_sequencer.sv
// Issues mul/div start pulses, stalls fetch while multdiv works, and
// produces one register-file writeback (result or rstatus code).
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int TIMEOUT    = 40,
    parameter int STATUS_MUL = STATUS_MUL_CODE,
    parameter int STATUS_DIV = STATUS_DIV_CODE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  opcode,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  rd,
    input  logic        md_ready,
    input  logic        md_exception,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        md_wb_en,
    output logic [4:0]  md_wb_rd,
    output logic        md_wb_status,
    output logic [31:0] status_value
);

    md_state_e   state;
    logic [4:0]  rd_q;
    logic        op_div_q;
    logic        wb_en_q;
    logic [4:0]  wb_rd_q;
    logic        wb_status_q;
    logic [31:0] status_q;

    logic dec_mul, dec_div, start, hit, busy_done, busy_exc;

    assign dec_mul = is_rtype_alu(opcode, alu_op, ALU_MUL);
    assign dec_div = is_rtype_alu(opcode, alu_op, ALU_DIV);

    // Start is Mealy on the IDLE decode; WB also sees the same decode but
    // is not IDLE, so it can never re-issue.
    assign start = !reset && (state == MD_IDLE) && (dec_mul || dec_div);

    // A timeout with no ready is reported as an exception.
    assign busy_done = md_ready || hit;
    assign busy_exc  = md_ready ? md_exception : 1'b1;

    md_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock (clock),
        .reset (reset),
        .clear (start),
        .en    (state == MD_BUSY),
        .hit   (hit)
    );

    // Sequencer FSM; writeback fields are registered on entry to WB.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= MD_IDLE;
            rd_q        <= '0;
            op_div_q    <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_status_q <= 1'b0;
            status_q    <= '0;
        end else begin
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_status_q <= 1'b0;
            status_q    <= '0;
            case (state)
                MD_IDLE: begin
                    if (dec_mul || dec_div) begin
                        rd_q     <= rd;
                        op_div_q <= dec_div;
                        state    <= MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    if (busy_done) begin
                        state <= MD_WB;
                        if (busy_exc) begin
                            wb_en_q     <= 1'b1;
                            wb_rd_q     <= REG_RSTATUS;
                            wb_status_q <= 1'b1;
                            status_q    <= op_div_q ? 32'(STATUS_DIV) : 32'(STATUS_MUL);
                        end else begin
                            wb_en_q     <= (rd_q != 5'd0);
                            wb_rd_q     <= rd_q;
                        end
                    end
                end
                MD_WB:   state <= MD_IDLE;
                default: state <= MD_IDLE;
            endcase
        end
    end

    // Every output is forced low while reset is asserted.
    assign ctrl_mult    = start && dec_mul;
    assign ctrl_div     = start && dec_div;
    assign stall        = start || (!reset && (state == MD_BUSY));
    assign md_wb_en     = wb_en_q && !reset;
    assign md_wb_rd     = reset ? 5'd0 : wb_rd_q;
    assign md_wb_status = wb_status_q && !reset;
    assign status_value = reset ? 32'd0 : status_q;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle sequencer for the multiply/divide unit in the single-cycle processor core. It detects R-type `mul` and `div` instructions and issues a one-cycle start pulse to the multdiv unit. It holds fetch/PC with a stall while the unit works, then produces a single register-file writeback with the product, quotient or exception status. It sits beside the opcode control decoder and overrides its register-write path only for `mul`/`div`.

## Interface
- `TIMEOUT`, default 40: maximum cycles spent in BUSY before a forced exception.
- `STATUS_MUL`, default 4: rstatus value written on mul exception.
- `STATUS_DIV`, default 5: rstatus value written on div exception.
- `clock  in  1`: single clock; all state updates on its rising edge.
- `reset  in  1`: synchronous, active-high; sampled on rising `clock`.
- `opcode  in  5`: instruction bits [31:27] of the current instruction.
- `alu_op  in  5`: instruction bits [6:2], the R-type ALU op field.
- `rd  in  5`: instruction bits [26:22], the destination register.
- `md_ready  in  1`: multdiv result valid, single-cycle pulse.
- `md_exception  in  1`: multdiv overflow or div-by-zero; valid only with `md_ready`.
- `ctrl_mult  out  1`: one-cycle multiply start pulse.
- `ctrl_div  out  1`: one-cycle divide start pulse.
- `stall  out  1`: freezes PC and fetch; the instruction stays presented.
- `md_wb_en  out  1`: register-file write enable for the multdiv result.
- `md_wb_rd  out  5`: write address.
- `md_wb_status  out  1`: 1 selects `status_value` as write data; 0 selects the multdiv result.
- `status_value  out  32`: zero-extended rstatus code.

## Operation
- Decode: `is_mul` = (opcode==00000 and alu_op==00110); `is_div` = (opcode==00000 and alu_op==00111).
- State machine states: IDLE, BUSY, WB. The encoding is 2-bit.
- IDLE:
  - If `is_mul` or `is_div`, assert `ctrl_mult`/`ctrl_div` and `stall` combinationally (Mealy) in the same cycle.
  - In that cycle, latch `rd` and the op type (mul/div), clear the counter, and go to BUSY.
  - Otherwise all outputs are 0.
- BUSY:
  - `stall`=1; start pulses are 0; the counter increments each cycle.
  - `md_ready`=1: latch `md_exception` and go to WB.
  - Counter == TIMEOUT-1 without `md_ready`: force the exception flag to 1 and go to WB.
- WB:
  - `stall`=0, so the PC advances at the end of this cycle. Go to IDLE unconditionally.
  - The same instruction is still decoded in WB. WB never re-issues a start.
  - No exception: `md_wb_en`=1 unless the latched rd==0, `md_wb_rd`=latched rd, `md_wb_status`=0.
  - Exception: `md_wb_en`=1, `md_wb_rd`=30, `md_wb_status`=1, `status_value`=STATUS_MUL or STATUS_DIV per the latched op.
- `md_ready` is ignored in IDLE and WB, and in the start cycle itself.
- `md_exception` without `md_ready` is ignored.
- Counter width is $clog2(TIMEOUT+1); it saturates and never wraps.

## Timing
- Start cycle T0 (IDLE, start pulse). Ready at T0+k, k≥1. WB at T0+k+1.
- `stall` is high for cycles T0..T0+k; the instruction occupies k+2 cycles total.
- Timeout: WB at T0+TIMEOUT+1 at latest.
- Back-to-back mul/div: the second start occurs in the IDLE cycle directly after WB.
- Reset value of every output is 0. State is IDLE; the counter and latches are cleared.
- Reset asserted mid-BUSY or in WB: the next cycle is IDLE, with no writeback and no start pulse. The multdiv unit is reset by the same `reset`.
- Reset high while a mul/div is decoded: no start pulse that cycle. Outputs are gated by reset.

## Structure
- Shared package/defines: R-type opcode 00000, ALU op codes MUL=00110 and DIV=00111, rstatus register index 30, STATUS_MUL/STATUS_DIV codes, state encodings. The control decoder uses the same constants.
- One sub-module: `md_timeout_counter`, a saturating up-counter with clear and a `hit` flag at TIMEOUT-1.
- Top-level mux integration: `md_wb_en` ORs into the register-file write enable. `md_wb_status`/`md_wb_rd` override the decoder's data and address selects.

## Test plan
- `mul` with rd=5, `md_ready` at k=3 with no exception:
  - `ctrl_mult` high for one cycle at T0 and `stall` high for 4 cycles.
  - WB writes r5 at T0+4 with `md_wb_status`=0.
- `div` with rd=7, `md_ready`+`md_exception` at k=2 -> WB at T0+3 writes r30, `md_wb_status`=1, `status_value`=5, no write to r7.
- `mul`, `md_ready` never arrives, TIMEOUT=40 -> WB at T0+41 writes r30 with value 4, and `stall` drops in WB.
- Two consecutive `div` instructions:
  - Each gets exactly one `ctrl_div` pulse; the second starts in the cycle after the first WB.
  - WB never re-triggers.
- `mul` with rd=0, normal completion -> `md_wb_en`=0 in WB, `stall` still drops, and the PC advances.
- Reset asserted at T0+2 of a `div` -> all outputs 0 the next cycle, state IDLE, no writeback. A stray `md_ready` arriving after reset is ignored.
